// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and legal parameter ranges.
// Also used by the receive side, so keep this package free of TX-only logic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int CLK_DIV_MIN   = 2;
  localparam int CLK_DIV_MAX   = 65535;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: free-running 0..CLK_DIV-1 counter; bit_end marks the final cycle of a period.
// restart forces the count back to 0 so a new frame starts a full period on its handshake edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
    $error("uart_baud_tick: CLK_DIV out of range");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per ready/valid handshake, framed as start, LSB-first data,
// optional parity and 1-2 stop bits; accepts a new word on the last stop cycle for gapless frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS out of range");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_frame: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD == PAR_ODD);

  tx_state_t            state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity;
  logic                 bit_end;
  logic                 last_stop;
  logic                 accept;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .bit_end(bit_end)
  );

  assign last_stop = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  assign tx_ready  = (state == IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;

  // A handshake always wins, which is what turns the last stop cycle straight into a new START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
    end else if (accept) begin
      state     <= START;
      bit_cnt   <= '0;
      shift_reg <= tx_data;
      parity    <= (^tx_data) ^ ODD_SEL;
      tx_out    <= 1'b0;
      tx_busy   <= 1'b1;
    end else if (bit_end) begin
      case (state)
        START: begin
          state     <= DATA;
          bit_cnt   <= '0;
          tx_out    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
        end
        DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
            if (PARITY_EN != 0) begin
              state  <= PARITY;
              tx_out <= parity;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 4'd1;
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        PARITY: begin
          state   <= STOP;
          bit_cnt <= '0;
          tx_out  <= 1'b1;
        end
        STOP: begin
          if (bit_cnt == LAST_STOP) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_busy <= 1'b0;
            tx_out  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations side by side, each checked against a
// per-cycle line model built from the frame rules (start, LSB-first data, parity, stop).
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] valid_v;
  logic [8:0] data_v;
  logic [2:0] out_v;
  logic [2:0] busy_v;
  logic [2:0] ready_v;

  int checks = 0;
  int failures = 0;

  // Configurations: 0 = even parity, 1 = odd parity, 2 = shortest (7N2, CLK_DIV=2)
  int cd [3] = '{4, 4, 2};
  int db [3] = '{8, 8, 7};
  int pe [3] = '{1, 1, 0};
  int po [3] = '{0, 1, 0};
  int sb [3] = '{1, 1, 2};

  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .tx_data(data_v[7:0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_out(out_v[0]), .tx_busy(busy_v[0]));

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(data_v[7:0]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_out(out_v[1]), .tx_busy(busy_v[1]));

  uart_tx_frame #(.CLK_DIV(2), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_short (
    .clk(clk), .rst(rst), .tx_data(data_v[6:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_out(out_v[2]), .tx_busy(busy_v[2]));

  function automatic int frame_len(input int s);
    return (1 + db[s] + pe[s] + sb[s]) * cd[s];
  endfunction

  // Append the expected per-cycle line level of one frame to exp_q.
  task automatic add_frame(input int s, input logic [8:0] d);
    bit bits[$];
    bit par;
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db[s]; i++) begin
      bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pe[s] != 0) bits.push_back(par ^ (po[s] != 0));
    for (int i = 0; i < sb[s]; i++) bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < cd[s]; c++) exp_q.push_back(bits[b]);
  endtask

  task automatic send_one(input int s, input logic [8:0] d, input string name);
    int len, errs, nbusy, first_bad;
    exp_q.delete();
    add_frame(s, d);
    len = exp_q.size();
    @(negedge clk);
    checks++;
    if (ready_v[s] !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_idle: got %b expected 1", name, ready_v[s]);
    end
    data_v = d;
    valid_v[s] = 1'b1;
    @(posedge clk);
    #1 valid_v[s] = 1'b0;
    data_v = 9'h1FF;
    errs = 0; nbusy = 0; first_bad = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (out_v[s] !== exp_q[k]) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy_v[s] === 1'b1) nbusy++;
    end
    @(negedge clk);
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s frame: %0d wrong cycles (first at cycle %0d), expected 0", name, errs, first_bad);
    end
    checks++;
    if (nbusy != len) begin
      failures++;
      $display("FAIL %s busy_len: got %0d cycles expected %0d", name, nbusy, len);
    end
    checks++;
    if (out_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: got out=%b busy=%b expected out=1 busy=0", name, out_v[s], busy_v[s]);
    end
  endtask

  // First frame d1; valid (re)asserted at cycle vcyc with dmid, switched to d2 at cycle 30.
  task automatic send_pair(input int s, input logic [8:0] d1, input int vcyc,
                           input logic [8:0] dmid, input logic [8:0] d2, input string name);
    int len, errs, nbusy, rdy_errs;
    bit exp_rdy;
    exp_q.delete();
    add_frame(s, d1);
    add_frame(s, d2);
    len = frame_len(s);
    @(negedge clk);
    data_v = d1;
    valid_v[s] = 1'b1;
    @(posedge clk);
    #1 valid_v[s] = (vcyc == 0);
    data_v = dmid;
    errs = 0; nbusy = 0; rdy_errs = 0;
    for (int k = 0; k < 2 * len; k++) begin
      @(negedge clk);
      if (out_v[s] !== exp_q[k]) errs++;
      if (busy_v[s] === 1'b1) nbusy++;
      exp_rdy = ((k % len) == len - 1);
      if (ready_v[s] !== exp_rdy) rdy_errs++;
      if (k + 1 == vcyc) valid_v[s] = 1'b1;
      if (k == 30) data_v = d2;
      if (k == len) valid_v[s] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s frames: %0d wrong cycles of %0d, expected 0", name, errs, 2 * len);
    end
    checks++;
    if (rdy_errs != 0) begin
      failures++;
      $display("FAIL %s ready: %0d wrong cycles, expected 0", name, rdy_errs);
    end
    checks++;
    if (nbusy != 2 * len) begin
      failures++;
      $display("FAIL %s busy_len: got %0d cycles expected %0d", name, nbusy, 2 * len);
    end
    checks++;
    if (out_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after: got out=%b busy=%b expected out=1 busy=0", name, out_v[s], busy_v[s]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || ready_v[s] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state[%0d]: got out=%b busy=%b ready=%b expected 1 0 1",
                 s, out_v[s], busy_v[s], ready_v[s]);
      end
    end
    // A handshake attempted during reset must be ignored.
    data_v = 9'h0A5;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_valid: got out=%b busy=%b expected out=1 busy=0", out_v[0], busy_v[0]);
    end
  endtask

  task automatic test_frame_a5();
    send_one(0, 9'h0A5, "frame_a5");
  endtask

  task automatic test_odd_parity();
    send_one(1, 9'h000, "odd_00");
    send_one(1, 9'h001, "odd_01");
  endtask

  task automatic test_shortest();
    send_one(2, 9'h07F, "short_7f");
    send_one(2, 9'h02A, "short_2a");
  endtask

  task automatic test_back_to_back();
    send_pair(0, 9'h055, 0, 9'h00F, 9'h00F, "b2b_55_0f");
  endtask

  task automatic test_valid_while_busy();
    send_pair(0, 9'h0A5, 10, 9'h033, 9'h03C, "busy_33_3c");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    data_v = 9'h0A5;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    // Data bit 3 occupies bit period 4, i.e. cycles 16..19.
    for (int k = 0; k < 18; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame: got out=%b busy=%b expected out=1 busy=0", out_v[0], busy_v[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_abandons_frame: got out=%b busy=%b ready=%b expected 1 0 1",
               out_v[0], busy_v[0], ready_v[0]);
    end
    send_one(0, 9'h05A, "after_reset_5a");
  endtask

  task automatic test_random();
    int s;
    logic [8:0] d1, d2;
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 2);
      d1 = 9'($urandom);
      send_one(s, d1, $sformatf("rand_one[%0d]", i));
    end
    for (int i = 0; i < 3; i++) begin
      s = $urandom_range(0, 1);
      d1 = 9'($urandom);
      d2 = 9'($urandom);
      send_pair(s, d1, 0, d2, d2, $sformatf("rand_pair[%0d]", i));
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_v = '0;
    data_v = '0;
    test_reset();
    test_frame_a5();
    test_odd_parity();
    test_shortest();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter and the next generation of the team's serial TX block. It serialises one data word per ready/valid handshake into an asynchronous frame: start bit, DATA_BITS data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits. Each bit is held for CLK_DIV clock cycles. It sits between the link framing logic (upstream, ready/valid) and the line driver (tx_out).

Parameters:
CLK_DIV, 16, clock cycles per bit period; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 1, 1 = parity bit present, 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 and 2.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset, asynchronous, active-high.
tx_data  in  DATA_BITS  word to send; sampled only on handshake.
tx_valid  in  1  upstream has a word.
tx_ready  out  1  block can accept a word this cycle.
tx_out  out  1  serial line; idle high.
tx_busy  out  1  a frame is on the line.

Behaviour:
- Reset values: tx_out=1, tx_busy=0, state=IDLE, and all counters 0. tx_ready is combinational, so it reads 1 during reset, but the handshake is ignored while rst=1.
- Handshake: a transfer occurs on a clk edge where tx_valid && tx_ready. tx_data is captured into a shift register on that edge; later changes to tx_data have no effect.
- tx_ready = (state==IDLE) || (last cycle of the final stop bit). tx_valid while tx_ready=0 is ignored and is not queued.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- If a handshake occurs in the last stop cycle, STOP goes directly to START with no idle gap.
- Latency: handshake at edge N drives tx_out low (start bit) from edge N and holds it for CLK_DIV cycles. tx_out is registered and glitch-free.
- DATA: sends shift_reg[0] and shifts right, for exactly DATA_BITS bit periods.
- Parity: even parity = XOR of all captured data bits. Odd parity = inverted XOR. Parity is computed at capture time.
- STOP: tx_out=1 for STOP_BITS*CLK_DIV cycles.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS)*CLK_DIV cycles.
- tx_busy=1 from the edge after the handshake through the last stop cycle. It stays 1 across back-to-back frames.
- Baud counter:
  - counts 0..CLK_DIV-1 and wraps;
  - its wrap ends a bit period;
  - it restarts at 0 on every handshake;
  - width is $clog2(CLK_DIV).
- Bit counter: 4 bits, cleared on every state change.
- Reset mid-frame: tx_out returns to 1 immediately and asynchronously, and the frame is abandoned with no completion. The next handshake after rst falls starts a clean frame.
- Illegal parameter values must cause an elaboration error.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_EVEN=0 and PAR_ODD=1;
  - the legal-range constants for DATA_BITS and STOP_BITS, reused by the future RX block.
- One sub-module, uart_baud_tick (parameter CLK_DIV; inputs clk, rst, restart; output bit_end pulse), also shared with RX.

Test Plan:
- Frame 0xA5: CLK_DIV=4, DATA_BITS=8, even parity, 1 stop; send 0xA5.
  -> tx_out, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, parity 0, 1.
  -> Frame is 44 cycles; tx_busy is high for exactly 44 cycles.
- Odd parity: PARITY_ODD=1; send 0x00.
  -> Parity bit = 1. Send 0x01: parity bit = 0.
- Back-to-back: tx_valid held high with 0x55 then 0x0F (same configuration as the 0xA5 case).
  -> Second start bit immediately follows the first stop bit.
  -> 88 contiguous cycles; tx_busy never drops.
- Shortest configuration: DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, CLK_DIV=2; send 0x7F.
  -> Bits 0, 1×7, 1, 1; frame is 20 cycles.
- Valid while busy: assert tx_valid with 0x33 mid-frame, then change it to 0x3C before tx_ready rises.
  -> No acceptance mid-frame.
  -> 0x3C is sent, as the value present at the handshake.
- Reset mid-frame: assert rst during data bit 3 of 0xA5.
  -> tx_out=1 and tx_busy=0 immediately.
  -> After rst release, sending 0x5A produces a correct full frame.
